bank_xbar_rsp_rob: RTL and testbench

Reorder buffer directly downstream of the bank SRAM controller's read-data port toward the crossbar. It accepts read beats tagged with channel id and ROB number, which can arrive out of order. It releases them strictly in ROB-number order per channel and arbitrates round-robin among channels onto a single response port. Storage: one 128-bit slot per (channel, rob_num).

---
 rtl/bank_xbar_rsp_rob.sv | 126 ++++++++++++
 tb/tb_bank_xbar_rsp_rob.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_xbar_rsp_rob.sv
// rtl/bank_xbar_rsp_rob.sv - per-channel read reorder buffer with round-robin response arbitration
// Beats land in (channel, rob_num) slots and leave strictly in head order per channel.
module bank_xbar_rsp_rob #(
   parameter int CH_NUM    = 4,
   parameter int ROB_DEPTH = 8,
   parameter int DW        = 128,
   localparam int CW = $clog2(CH_NUM),
   localparam int RW = $clog2(ROB_DEPTH),
   localparam int NW = $clog2(ROB_DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sc_xbar_valid_i,
   output logic              sc_xbar_ready_o,
   input  logic [CW-1:0]     sc_xbar_channel_id_i,
   input  logic [RW-1:0]     sc_xbar_rob_num_i,
   input  logic [DW-1:0]     sc_xbar_data_i,
   output logic              xbar_rsp_valid_o,
   input  logic              xbar_rsp_ready_i,
   output logic [CW-1:0]     xbar_rsp_channel_id_o,
   output logic [RW-1:0]     xbar_rsp_rob_num_o,
   output logic [DW-1:0]     xbar_rsp_data_o,
   output logic [CH_NUM-1:0] rob_empty_o
);

   logic [CH_NUM-1:0][ROB_DEPTH-1:0] vld_q, vld_d;
   logic [DW-1:0]                    data_q [CH_NUM][ROB_DEPTH];
   logic [CH_NUM-1:0][RW-1:0]        head_q, head_d;
   logic [CW-1:0]                    rr_ptr_q, rr_ptr_d;
   logic [CH_NUM-1:0][NW-1:0]        cnt_q, cnt_d;

   logic [CH_NUM-1:0] hv;
   logic              gnt_vld;
   logic [CW-1:0]     gnt_ch;
   logic [CW-1:0]     scan_ch;
   logic              wr_en;
   logic              pop_en;

   // Ready looks only at registered occupancy, so a slot freed this cycle reopens next cycle.
   assign sc_xbar_ready_o = ~vld_q[sc_xbar_channel_id_i][sc_xbar_rob_num_i];
   assign wr_en           = sc_xbar_valid_i & sc_xbar_ready_o;
   assign pop_en          = gnt_vld & xbar_rsp_ready_i;

   always_comb begin
      for (int c = 0; c < CH_NUM; c++) begin
         hv[c] = vld_q[c][head_q[c]];
      end
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = '0;
      scan_ch = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         scan_ch = rr_ptr_q + CW'(i);
         if (!gnt_vld && hv[scan_ch]) begin
            gnt_vld = 1'b1;
            gnt_ch  = scan_ch;
         end
      end
   end

   always_comb begin
      vld_d    = vld_q;
      head_d   = head_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en) begin
         vld_d[sc_xbar_channel_id_i][sc_xbar_rob_num_i] = 1'b1;
      end
      if (pop_en) begin
         vld_d[gnt_ch][head_q[gnt_ch]] = 1'b0;
         head_d[gnt_ch]                = head_q[gnt_ch] + RW'(1);
         rr_ptr_d                      = gnt_ch + CW'(1);
      end
      for (int c = 0; c < CH_NUM; c++) begin
         case ({wr_en && (sc_xbar_channel_id_i == CW'(c)), pop_en && (gnt_ch == CW'(c))})
            2'b10:   cnt_d[c] = cnt_q[c] + NW'(1);
            2'b01:   cnt_d[c] = cnt_q[c] - NW'(1);
            default: cnt_d[c] = cnt_q[c];
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q    <= '0;
         head_q   <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         vld_q    <= vld_d;
         head_q   <= head_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload storage carries no reset; occupancy bits alone say what is live.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         data_q[sc_xbar_channel_id_i][sc_xbar_rob_num_i] <= sc_xbar_data_i;
      end
   end

   assign xbar_rsp_valid_o      = gnt_vld;
   assign xbar_rsp_channel_id_o = gnt_ch;
   assign xbar_rsp_rob_num_o    = head_q[gnt_ch];
   assign xbar_rsp_data_o       = gnt_vld ? data_q[gnt_ch][head_q[gnt_ch]] : '0;

   always_comb begin
      for (int c = 0; c < CH_NUM; c++) begin
         rob_empty_o[c] = (cnt_q[c] == '0);
      end
   end

`ifndef SYNTHESIS
   for (genvar c = 0; c < CH_NUM; c++) begin : g_cnt_chk
      a_cnt_matches_vld: assert property (@(posedge clk_i) disable iff (rst_i)
         cnt_q[c] == NW'($countones(vld_q[c])));
   end
   a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      pop_en |-> (cnt_q[gnt_ch] != '0));
`endif

endmodule

// File: tb/tb_bank_xbar_rsp_rob.sv
// tb/tb_bank_xbar_rsp_rob.sv - vector table plus response scoreboard for bank_xbar_rsp_rob
module tb_bank_xbar_rsp_rob;

   logic         clk_i;
   logic         rst_i;
   logic         sc_xbar_valid_i;
   logic         sc_xbar_ready_o;
   logic [1:0]   sc_xbar_channel_id_i;
   logic [2:0]   sc_xbar_rob_num_i;
   logic [127:0] sc_xbar_data_i;
   logic         xbar_rsp_valid_o;
   logic         xbar_rsp_ready_i;
   logic [1:0]   xbar_rsp_channel_id_o;
   logic [2:0]   xbar_rsp_rob_num_o;
   logic [127:0] xbar_rsp_data_o;
   logic [3:0]   rob_empty_o;

   bank_xbar_rsp_rob dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .sc_xbar_valid_i      (sc_xbar_valid_i),
      .sc_xbar_ready_o      (sc_xbar_ready_o),
      .sc_xbar_channel_id_i (sc_xbar_channel_id_i),
      .sc_xbar_rob_num_i    (sc_xbar_rob_num_i),
      .sc_xbar_data_i       (sc_xbar_data_i),
      .xbar_rsp_valid_o     (xbar_rsp_valid_o),
      .xbar_rsp_ready_i     (xbar_rsp_ready_i),
      .xbar_rsp_channel_id_o(xbar_rsp_channel_id_o),
      .xbar_rsp_rob_num_o   (xbar_rsp_rob_num_o),
      .xbar_rsp_data_o      (xbar_rsp_data_o),
      .rob_empty_o          (rob_empty_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   typedef struct {
      logic         wr;
      logic [1:0]   ch;
      logic [2:0]   rob;
      logic [127:0] data;
      logic         rdy;
      logic         exp_scr;
      logic         exp_v;
      logic [1:0]   exp_ch;
      logic [2:0]   exp_rob;
      logic [3:0]   exp_empty;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   int total = 0;
   int bad   = 0;
   logic [132:0] exp_q [$];
   logic [132:0] mon_e;

   task automatic chk(input string name, input logic [132:0] act, input logic [132:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Every accepted response must match the oldest outstanding expectation.
   always @(negedge clk_i) begin
      if (!rst_i && xbar_rsp_valid_o && xbar_rsp_ready_i) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {xbar_rsp_channel_id_o, xbar_rsp_rob_num_o, xbar_rsp_data_o}, 133'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp", {xbar_rsp_channel_id_o, xbar_rsp_rob_num_o, xbar_rsp_data_o}, mon_e);
         end
      end
   end

   task automatic drive(input logic v, input logic [1:0] ch, input logic [2:0] rob,
                        input logic [127:0] d, input logic rdy);
      sc_xbar_valid_i      = v;
      sc_xbar_channel_id_i = ch;
      sc_xbar_rob_num_i    = rob;
      sc_xbar_data_i       = d;
      xbar_rsp_ready_i     = rdy;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 2'd0, 3'd0, 128'd0, 1'b0);
      rst_i = 1'b1;
      next_cycle();
      rst_i = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         next_cycle();
         n++;
      end
      chk(name, 133'(exp_q.size()), 133'd0);
   endtask

   task automatic push(input logic [1:0] ch, input logic [2:0] rob, input logic [127:0] d);
      exp_q.push_back({ch, rob, d});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 2'd0, 3'd0, 128'hA0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1111};
      tbl[1]  = '{1'b1, 2'd0, 3'd1, 128'hA1, 1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 4'b1110};
      tbl[2]  = '{1'b1, 2'd0, 3'd2, 128'hA2, 1'b1, 1'b1, 1'b1, 2'd0, 3'd1, 4'b1110};
      tbl[3]  = '{1'b0, 2'd0, 3'd0, 128'h0,  1'b1, 1'b1, 1'b1, 2'd0, 3'd2, 4'b1110};
      tbl[4]  = '{1'b0, 2'd0, 3'd0, 128'h0,  1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1111};
      tbl[5]  = '{1'b1, 2'd1, 3'd2, 128'hB2, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1111};
      tbl[6]  = '{1'b1, 2'd1, 3'd1, 128'hB1, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1101};
      tbl[7]  = '{1'b1, 2'd1, 3'd0, 128'hB0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1101};
      tbl[8]  = '{1'b0, 2'd1, 3'd2, 128'h0,  1'b1, 1'b0, 1'b1, 2'd1, 3'd0, 4'b1101};
      tbl[9]  = '{1'b0, 2'd1, 3'd2, 128'h0,  1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 4'b1101};
      tbl[10] = '{1'b0, 2'd1, 3'd2, 128'h0,  1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 4'b1101};
      tbl[11] = '{1'b1, 2'd1, 3'd3, 128'hB3, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1111};
      tbl[12] = '{1'b0, 2'd1, 3'd3, 128'h0,  1'b1, 1'b0, 1'b1, 2'd1, 3'd3, 4'b1101};
      tbl[13] = '{1'b0, 2'd0, 3'd0, 128'h0,  1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1111};

      drive(1'b0, 2'd0, 3'd0, 128'd0, 1'b0);
      rst_i = 1'b1;
      #1;
      chk("reset_valid", 133'(xbar_rsp_valid_o), 133'd0);
      chk("reset_empty", 133'(rob_empty_o), 133'hF);
      chk("reset_sc_ready", 133'(sc_xbar_ready_o), 133'd1);
      next_cycle();
      rst_i = 1'b0;

      // In-order on ch0, then out-of-order on ch1 followed by rob3 proving head advanced to 3.
      push(2'd0, 3'd0, 128'hA0); push(2'd0, 3'd1, 128'hA1); push(2'd0, 3'd2, 128'hA2);
      push(2'd1, 3'd0, 128'hB0); push(2'd1, 3'd1, 128'hB1); push(2'd1, 3'd2, 128'hB2);
      push(2'd1, 3'd3, 128'hB3);
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].wr, tbl[i].ch, tbl[i].rob, tbl[i].data, tbl[i].rdy);
         @(negedge clk_i);
         chk($sformatf("vec%0d_sc_ready", i), 133'(sc_xbar_ready_o), 133'(tbl[i].exp_scr));
         chk($sformatf("vec%0d_valid", i), 133'(xbar_rsp_valid_o), 133'(tbl[i].exp_v));
         chk($sformatf("vec%0d_empty", i), 133'(rob_empty_o), 133'(tbl[i].exp_empty));
         if (tbl[i].exp_v) begin
            chk($sformatf("vec%0d_ch_rob", i), 133'({xbar_rsp_channel_id_o, xbar_rsp_rob_num_o}),
                133'({tbl[i].exp_ch, tbl[i].exp_rob}));
         end else begin
            chk($sformatf("vec%0d_idle_data", i), 133'(xbar_rsp_data_o), 133'd0);
         end
         next_cycle();
      end
      chk("table_sb_empty", 133'(exp_q.size()), 133'd0);

      // Round-robin from rr_ptr=0 across ch0, ch2, ch3.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, (i / 2 == 0) ? 2'd0 : ((i / 2 == 1) ? 2'd2 : 2'd3), 3'(i % 2), 128'h100 + 128'(i), 1'b0);
         next_cycle();
      end
      push(2'd0, 3'd0, 128'h100); push(2'd2, 3'd0, 128'h102); push(2'd3, 3'd0, 128'h104);
      push(2'd0, 3'd1, 128'h101); push(2'd2, 3'd1, 128'h103); push(2'd3, 3'd1, 128'h105);
      drive(1'b0, 2'd0, 3'd0, 128'd0, 1'b1);
      drain("rr_drain", 20);

      // ch3 fills all eight slots under backpressure; a ninth beat to rob0 must wait.
      do_reset();
      for (int r = 0; r < 8; r++) begin
         drive(1'b1, 2'd3, 3'(r), 128'hC0 + 128'(r), 1'b0);
         @(negedge clk_i);
         chk($sformatf("fill%0d_sc_ready", r), 133'(sc_xbar_ready_o), 133'd1);
         next_cycle();
         push(2'd3, 3'(r), 128'hC0 + 128'(r));
      end
      push(2'd3, 3'd0, 128'hC8);
      drive(1'b1, 2'd3, 3'd0, 128'hC8, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         chk("full_sc_ready", 133'(sc_xbar_ready_o), 133'd0);
         chk("full_head", 133'({xbar_rsp_valid_o, xbar_rsp_channel_id_o, xbar_rsp_rob_num_o}), 133'({1'b1, 2'd3, 3'd0}));
         chk("full_empty", 133'(rob_empty_o), 133'b0111);
         next_cycle();
      end
      xbar_rsp_ready_i = 1'b1;
      @(negedge clk_i);
      chk("pop_cycle_sc_ready", 133'(sc_xbar_ready_o), 133'd0);
      next_cycle();
      @(negedge clk_i);
      chk("after_pop_sc_ready", 133'(sc_xbar_ready_o), 133'd1);
      chk("after_pop_rob", 133'(xbar_rsp_rob_num_o), 133'd1);
      next_cycle();
      sc_xbar_valid_i = 1'b0;
      drain("wrap_drain", 40);
      @(negedge clk_i);
      chk("wrap_empty", 133'(rob_empty_o), 133'hF);

      // Pop ch0 rob0 while writing ch0 rob5 in the same cycle.
      next_cycle();
      drive(1'b1, 2'd0, 3'd0, 128'hE0, 1'b0);
      next_cycle();
      push(2'd0, 3'd0, 128'hE0);
      drive(1'b1, 2'd0, 3'd5, 128'hE5, 1'b1);
      @(negedge clk_i);
      chk("simul_sc_ready", 133'(sc_xbar_ready_o), 133'd1);
      chk("simul_head", 133'({xbar_rsp_valid_o, xbar_rsp_rob_num_o}), 133'({1'b1, 3'd0}));
      next_cycle();
      drive(1'b0, 2'd0, 3'd5, 128'd0, 1'b1);
      @(negedge clk_i);
      chk("simul_empty", 133'(rob_empty_o), 133'b1110);
      chk("simul_valid", 133'(xbar_rsp_valid_o), 133'd0);
      chk("simul_slot5_taken", 133'(sc_xbar_ready_o), 133'd0);
      chk("simul_sb_empty", 133'(exp_q.size()), 133'd0);
      next_cycle();

      // Asynchronous reset with three beats pending on ch2.
      for (int r = 0; r < 3; r++) begin
         drive(1'b1, 2'd2, 3'(r), 128'hD0 + 128'(r), 1'b0);
         next_cycle();
      end
      drive(1'b0, 2'd0, 3'd0, 128'd0, 1'b0);
      chk("pre_reset_valid", 133'(xbar_rsp_valid_o), 133'd1);
      rst_i = 1'b1;
      #1;
      chk("async_reset_valid", 133'(xbar_rsp_valid_o), 133'd0);
      chk("async_reset_empty", 133'(rob_empty_o), 133'hF);
      chk("async_reset_data", 133'(xbar_rsp_data_o), 133'd0);
      next_cycle();
      rst_i = 1'b0;
      push(2'd2, 3'd0, 128'hDD);
      drive(1'b1, 2'd2, 3'd0, 128'hDD, 1'b1);
      @(negedge clk_i);
      chk("post_reset_sc_ready", 133'(sc_xbar_ready_o), 133'd1);
      chk("post_reset_no_bypass", 133'(xbar_rsp_valid_o), 133'd0);
      next_cycle();
      sc_xbar_valid_i = 1'b0;
      @(negedge clk_i);
      chk("post_reset_head", 133'({xbar_rsp_valid_o, xbar_rsp_channel_id_o, xbar_rsp_rob_num_o}), 133'({1'b1, 2'd2, 3'd0}));
      next_cycle();
      drain("post_reset_drain", 10);

      chk("final_sb_empty", 133'(exp_q.size()), 133'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
